// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between the
// ALU (Req0) and the load/multi-cycle unit (Req1), with a registered write stage.
module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Hold,
    input  logic              Req0Valid,
    input  logic [ADDR_W-1:0] Req0Addr,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADDR_W-1:0] Req1Addr,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              HitA,
    output logic              HitB,
    output logic [CNT_W-1:0]  WrCount
);

    localparam logic [ADDR_W-1:0] ZeroReg = '1;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
        satInc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    logic              prioPtr;
    logic              grant0;
    logic              grant1;
    logic              anyGrant;
    logic              commit;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    logic              vld_p1;
    logic [ADDR_W-1:0] rw_p1;
    logic [DATA_W-1:0] busW_p1;
    logic [CNT_W-1:0]  wrCount_p1;

    // Stage 0: combinational arbitration; prioPtr names the winner on contention
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Reset && !Hold) begin
            if (Req0Valid && (!Req1Valid || !prioPtr)) begin
                grant0 = 1'b1;
            end else if (Req1Valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign selAddr   = grant1 ? Req1Addr : Req0Addr;
    assign selData   = grant1 ? Req1Data : Req0Data;
    assign anyGrant  = grant0 | grant1;
    assign commit    = anyGrant && (selAddr != ZeroReg);
    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    // Stage 1: registered write stage feeding the register file write port
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p1     <= 1'b0;
            rw_p1      <= '0;
            busW_p1    <= '0;
            wrCount_p1 <= '0;
            prioPtr    <= 1'b0;
        end else begin
            vld_p1 <= commit;
            if (anyGrant) begin
                rw_p1   <= selAddr;
                busW_p1 <= selData;
                prioPtr <= grant0;
            end
            if (commit) begin
                wrCount_p1 <= satInc(wrCount_p1);
            end
        end
    end

    assign RegWr   = vld_p1;
    assign RW      = rw_p1;
    assign BusW    = busW_p1;
    assign WrCount = wrCount_p1;

    // Forwarding hits let same-cycle readers take BusW before the negedge write lands
    assign HitA = vld_p1 && (rw_p1 == RA) && (RA != ZeroReg);
    assign HitB = vld_p1 && (rw_p1 == RB) && (RB != ZeroReg);

endmodule
